// File: rtl/eth_10g_st_pkg.sv
`default_nettype none
// ============================================================================
// Module : eth_10g_st_pkg
// Brief  : Shared Avalon-ST beat type and arbiter state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
package eth_10g_st_pkg;

   localparam int ST_DATA_W  = 64;
   localparam int ST_EMPTY_W = 3;

   typedef struct packed {
      logic [ST_DATA_W-1:0]  data;
      logic                  error;
      logic                  sop;
      logic                  eop;
      logic [ST_EMPTY_W-1:0] empty;
   } st_beat_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_10g_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module : eth_10g_rr_pick2
// Brief  : Two-way round-robin pick; rr_ptr_i breaks ties only.
// Rev    : 1.0 - initial release
// ============================================================================
module eth_10g_rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       rr_ptr_i,
   output logic       winner_o,
   output logic       any_req_o
);

   always_comb begin
      any_req_o = |req_i;
      winner_o  = (req_i == 2'b11) ? rr_ptr_i : req_i[1];
   end

endmodule
`default_nettype wire

// File: rtl/eth_10g_rx_st_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module : eth_10g_rx_st_pkt_arbiter
// Brief  : Packet-granular 2:1 round-robin Avalon-ST RX arbiter.
//          Optional statistics counters under ETH_RX_ARB_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module eth_10g_rx_st_pkt_arbiter
   import eth_10g_st_pkg::*;
#(
   parameter int DATA_W  = ST_DATA_W,
   parameter int EMPTY_W = ST_EMPTY_W,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in0_valid,
   input  logic [DATA_W-1:0]  in0_data,
   input  logic               in0_error,
   input  logic               in0_startofpacket,
   input  logic               in0_endofpacket,
   input  logic [EMPTY_W-1:0] in0_empty,
   output logic               in0_ready,
   input  logic               in1_valid,
   input  logic [DATA_W-1:0]  in1_data,
   input  logic               in1_error,
   input  logic               in1_startofpacket,
   input  logic               in1_endofpacket,
   input  logic [EMPTY_W-1:0] in1_empty,
   output logic               in1_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_error,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic [EMPTY_W-1:0] out_empty,
   input  logic               out_ready,
   output logic               grant_id,
   output logic               busy,
   output logic               proto_err
`ifdef ETH_RX_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]   pkt_cnt0,
   output logic [CNT_W-1:0]   pkt_cnt1,
   output logic [CNT_W-1:0]   drop_cnt
`endif
);

   arb_state_t state_q, state_d;
   logic       rr_ptr_q, rr_ptr_d;
   logic       grant_q, grant_d;
   logic       proto_err_q, proto_err_d;

   st_beat_t   w_beat0, w_beat1, w_sel_beat;
   logic [1:0] w_req;
   logic       w_winner, w_any_req;
   logic       w_drop0, w_drop1;
   logic       w_sel_valid, w_xfer_eop;

   assign w_beat0 = '{data: in0_data, error: in0_error, sop: in0_startofpacket,
                      eop: in0_endofpacket, empty: in0_empty};
   assign w_beat1 = '{data: in1_data, error: in1_error, sop: in1_startofpacket,
                      eop: in1_endofpacket, empty: in1_empty};

   assign w_sel_beat  = grant_q ? w_beat1 : w_beat0;
   assign w_sel_valid = grant_q ? in1_valid : in0_valid;
   assign w_req       = {in1_valid & in1_startofpacket, in0_valid & in0_startofpacket};

   // Non-SOP beats seen while idle are accepted and thrown away
   assign w_drop0 = (state_q == IDLE) & in0_valid & ~in0_startofpacket;
   assign w_drop1 = (state_q == IDLE) & in1_valid & ~in1_startofpacket;

   assign w_xfer_eop = (state_q == LOCK) & w_sel_valid & out_ready & w_sel_beat.eop;

   eth_10g_rr_pick2 u_pick (
      .req_i     (w_req),
      .rr_ptr_i  (rr_ptr_q),
      .winner_o  (w_winner),
      .any_req_o (w_any_req)
   );

   always_comb begin
      state_d           = state_q;
      rr_ptr_d          = rr_ptr_q;
      grant_d           = grant_q;
      proto_err_d       = proto_err_q | w_drop0 | w_drop1;
      out_valid         = 1'b0;
      out_data          = '0;
      out_error         = 1'b0;
      out_startofpacket = 1'b0;
      out_endofpacket   = 1'b0;
      out_empty         = '0;
      in0_ready         = w_drop0;
      in1_ready         = w_drop1;
      case (state_q)
         IDLE: begin
            if (w_any_req) begin
               state_d = LOCK;
               grant_d = w_winner;
            end
         end
         LOCK: begin
            out_valid         = w_sel_valid;
            out_data          = w_sel_beat.data;
            out_error         = w_sel_beat.error;
            out_startofpacket = w_sel_beat.sop;
            out_endofpacket   = w_sel_beat.eop;
            out_empty         = w_sel_beat.empty;
            in0_ready         = ~grant_q & out_ready;
            in1_ready         = grant_q & out_ready;
            if (w_xfer_eop) begin
               state_d  = IDLE;
               rr_ptr_d = ~grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= 1'b0;
         grant_q     <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign grant_id  = grant_q;
   assign busy      = (state_q == LOCK);
   assign proto_err = proto_err_q;

`ifdef ETH_RX_ARB_STATS_EN
   logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt1_q, drop_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt0_q <= '0;
         pkt_cnt1_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (w_xfer_eop && !grant_q) pkt_cnt0_q <= pkt_cnt0_q + 1'b1;
         if (w_xfer_eop &&  grant_q) pkt_cnt1_q <= pkt_cnt1_q + 1'b1;
         drop_cnt_q <= drop_cnt_q + CNT_W'(w_drop0) + CNT_W'(w_drop1);
      end
   end

   assign pkt_cnt0 = pkt_cnt0_q;
   assign pkt_cnt1 = pkt_cnt1_q;
   assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_10g_rx_st_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_eth_10g_rx_st_pkt_arbiter
// Brief  : Randomized bench for the RX packet arbiter against a packet-level
//          model (ownership, tie alternation, drops, sticky error).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_eth_10g_rx_st_pkt_arbiter;

   localparam int DW      = 64;
   localparam int EW      = 3;
   localparam int CW      = 32;
   localparam int N_CYC   = 3000;
   localparam int RST_A   = 1000;
   localparam int RST_B   = 2100;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    vld, sop, eop, err;
   logic [DW-1:0] dat [2];
   logic [EW-1:0] emp [2];
   logic          rdy0, rdy1;
   logic          o_valid, o_err, o_sop, o_eop, o_rdy;
   logic [DW-1:0] o_data;
   logic [EW-1:0] o_empty;
   logic          gnt, busy, perr;
`ifdef ETH_RX_ARB_STATS_EN
   logic [CW-1:0] pc0, pc1, dc;
`endif

   always #5 clk = ~clk;

   eth_10g_rx_st_pkt_arbiter #(.DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW)) dut (
      .clk               (clk),
      .reset             (reset),
      .in0_valid         (vld[0]),
      .in0_data          (dat[0]),
      .in0_error         (err[0]),
      .in0_startofpacket (sop[0]),
      .in0_endofpacket   (eop[0]),
      .in0_empty         (emp[0]),
      .in0_ready         (rdy0),
      .in1_valid         (vld[1]),
      .in1_data          (dat[1]),
      .in1_error         (err[1]),
      .in1_startofpacket (sop[1]),
      .in1_endofpacket   (eop[1]),
      .in1_empty         (emp[1]),
      .in1_ready         (rdy1),
      .out_valid         (o_valid),
      .out_data          (o_data),
      .out_error         (o_err),
      .out_startofpacket (o_sop),
      .out_endofpacket   (o_eop),
      .out_empty         (o_empty),
      .out_ready         (o_rdy),
      .grant_id          (gnt),
      .busy              (busy),
      .proto_err         (perr)
`ifdef ETH_RX_ARB_STATS_EN
      ,
      .pkt_cnt0          (pc0),
      .pkt_cnt1          (pc1),
      .drop_cnt          (dc)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Source drivers: a held beat stays presented until accepted
   bit pend  [2];
   bit stray [2];
   int rem   [2];

   task automatic present(input int s);
      if (!pend[s] && $urandom_range(0, 9) < 6) begin
         pend[s] = 1'b1;
         dat[s]  = {$urandom, $urandom};
         err[s]  = 1'($urandom);
         emp[s]  = EW'($urandom);
         if (rem[s] == 0 && $urandom_range(0, 9) == 0) begin
            stray[s] = 1'b1;
            sop[s]   = 1'b0;
            eop[s]   = 1'($urandom);
         end else if (rem[s] == 0) begin
            stray[s] = 1'b0;
            rem[s]   = $urandom_range(1, 5);
            sop[s]   = 1'b1;
            eop[s]   = (rem[s] == 1);
         end else begin
            stray[s] = 1'b0;
            sop[s]   = 1'b0;
            eop[s]   = (rem[s] == 1);
         end
      end
      vld[s] = pend[s];
   endtask

   // Reference model: who owns the sink, who wins the next tie, sticky error
   bit owned, owner, tie_to, m_perr;
   int m_pkt [2];
   int m_drop;

   initial begin
      logic [1:0]    e_rdy, xfer, req;
      logic          e_ov, e_err, e_sop, e_eop;
      logic [DW-1:0] e_data;
      logic [EW-1:0] e_emp;

      reset = 1'b1;
      vld = '0; sop = '0; eop = '0; err = '0; o_rdy = 1'b0;
      for (int s = 0; s < 2; s++) begin
         dat[s] = '0; emp[s] = '0; pend[s] = 0; rem[s] = 0; stray[s] = 0; m_pkt[s] = 0;
      end
      owned = 0; owner = 0; tie_to = 0; m_perr = 0; m_drop = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", gnt, 0);
      chk("rst_proto_err", perr, 0);
      chk("rst_out_valid", o_valid, 0);
      chk("rst_in0_ready", rdy0, 0);
      chk("rst_in1_ready", rdy1, 0);

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(negedge clk);
         reset = (cyc == RST_A) || (cyc == RST_B);
         present(0);
         present(1);
         o_rdy = ($urandom_range(0, 3) != 0);
         #1;

         e_rdy = '0; e_ov = 0; e_data = '0; e_err = 0; e_sop = 0; e_eop = 0; e_emp = '0;
         if (!owned) begin
            e_rdy = vld & ~sop;
         end else begin
            e_ov          = vld[owner];
            e_data        = dat[owner];
            e_err         = err[owner];
            e_sop         = sop[owner];
            e_eop         = eop[owner];
            e_emp         = emp[owner];
            e_rdy[owner]  = o_rdy;
         end
         chk("out_valid", o_valid, e_ov);
         chk("out_data", o_data, e_data);
         chk("out_error", o_err, e_err);
         chk("out_sop", o_sop, e_sop);
         chk("out_eop", o_eop, e_eop);
         chk("out_empty", o_empty, e_emp);
         chk("in0_ready", rdy0, e_rdy[0]);
         chk("in1_ready", rdy1, e_rdy[1]);
         chk("busy", busy, owned);
         chk("grant_id", gnt, owner);
         chk("proto_err", perr, m_perr);

         xfer = vld & e_rdy;
         req  = vld & sop;
         @(posedge clk);

         if (reset) begin
            owned = 0; owner = 0; tie_to = 0; m_perr = 0;
            m_pkt[0] = 0; m_pkt[1] = 0; m_drop = 0;
         end else if (!owned) begin
            if (xfer != 2'b00) begin
               m_perr = 1;
               m_drop += int'(xfer[0]) + int'(xfer[1]);
            end
            if (req != 2'b00) begin
               owned = 1;
               owner = (req == 2'b11) ? tie_to : req[1];
            end
         end else if (xfer[owner] && eop[owner]) begin
            owned  = 0;
            tie_to = !owner;
            m_pkt[owner]++;
         end

         for (int s = 0; s < 2; s++) begin
            if (reset) begin
               pend[s] = 0;
               rem[s]  = 0;
            end else if (xfer[s]) begin
               pend[s] = 0;
               if (!stray[s]) rem[s]--;
            end
         end
      end

      @(negedge clk);
`ifdef ETH_RX_ARB_STATS_EN
      chk("pkt_cnt0", pc0, CW'(m_pkt[0]));
      chk("pkt_cnt1", pc1, CW'(m_pkt[1]));
      chk("drop_cnt", dc, CW'(m_drop));
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
